// File: rtl/ps2_scancode_receiver_if.sv
// PS/2 receiver bus: raw keyboard lines in, folded event word and frame error pulse out.
interface ps2_scancode_receiver_if;
    logic        ps2_clk_in;
    logic        ps2_data_in;
    logic [10:0] ps2_key;
    logic        frame_err;

    modport master (
        output ps2_clk_in,
        output ps2_data_in,
        input  ps2_key,
        input  frame_err
    );

    modport slave (
        input  ps2_clk_in,
        input  ps2_data_in,
        output ps2_key,
        output frame_err
    );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: filters the raw lines, deframes bytes, folds E0/F0/E1 prefixes into a toggle-marked event word.
// Optional build macro TYPEMATIC_SUPPRESS_EN drops repeated makes of a key that is already held.
module ps2_scancode_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    ps2_scancode_receiver_if.slave   bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    function automatic logic is_response(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_response = 1'b1;
            default:                                          is_response = 1'b0;
        endcase
    endfunction

    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic          data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    logic          filt_clk_q, filt_clk_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          ext_q, ext_d, rel_q, rel_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   key_q, key_d;
    logic          err_q, err_d;
    logic          fall_s, byte_ok_s;
`ifdef TYPEMATIC_SUPPRESS_EN
    logic [511:0]  held_q, held_d;
    logic [8:0]    idx_s;
`endif

    assign bus.ps2_key   = key_q;
    assign bus.frame_err = err_q;

    // Next-state logic: input filtering, framing FSM, timeout and prefix folding.
    always_comb begin
        clk_meta_d  = bus.ps2_clk_in;
        clk_sync_d  = clk_meta_q;
        data_meta_d = bus.ps2_data_in;
        data_sync_d = data_meta_q;
        filt_clk_d  = filt_clk_q;
        filt_cnt_d  = filt_cnt_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tmo_cnt_d   = tmo_cnt_q;
        ext_d       = ext_q;
        rel_d       = rel_q;
        skip_d      = skip_q;
        key_d       = key_q;
        err_d       = 1'b0;
        fall_s      = 1'b0;
        byte_ok_s   = 1'b0;
`ifdef TYPEMATIC_SUPPRESS_EN
        held_d      = held_q;
        idx_s       = {ext_q, shift_q};
`endif

        // Filtered clock follows the synchronized line only after FILTER_LEN differing samples.
        if (clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_clk_d = clk_sync_q;
                filt_cnt_d = '0;
                fall_s     = filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end else begin
            filt_cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                tmo_cnt_d = '0;
                if (fall_s) begin
                    if (!data_sync_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (fall_s) begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (fall_s) begin
                    parity_d = data_sync_q;
                    state_d  = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (fall_s) begin
                    state_d = S_IDLE;
                    if (data_sync_q && parity_ok(shift_q, parity_q)) begin
                        byte_ok_s = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE) begin
            if (fall_s) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
                tmo_cnt_d = '0;
                state_d   = S_IDLE;
                err_d     = 1'b1;
                ext_d     = 1'b0;
                rel_d     = 1'b0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end else begin
            tmo_cnt_d = '0;
        end

        // The E1 Pause sequence carries seven more bytes that must never reach the matrix.
        if (byte_ok_s) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (shift_q == 8'hE1) begin
                skip_d = 3'd7;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                rel_d = 1'b1;
            end else if (is_response(shift_q)) begin
                ext_d = 1'b0;
                rel_d = 1'b0;
            end else begin
                ext_d = 1'b0;
                rel_d = 1'b0;
`ifdef TYPEMATIC_SUPPRESS_EN
                if (rel_q) begin
                    held_d[idx_s] = 1'b0;
                    key_d         = {~key_q[10], ~rel_q, ext_q, shift_q};
                end else if (held_q[idx_s]) begin
                    key_d = key_q;
                end else begin
                    held_d[idx_s] = 1'b1;
                    key_d         = {~key_q[10], ~rel_q, ext_q, shift_q};
                end
`else
                key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
`endif
            end
        end else begin
            skip_d = skip_q;
        end
    end

    // State register with synchronous active-low reset; idle lines are high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            skip_q      <= 3'd0;
            key_q       <= 11'h000;
            err_q       <= 1'b0;
`ifdef TYPEMATIC_SUPPRESS_EN
            held_q      <= '0;
`endif
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_cnt_q   <= tmo_cnt_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            skip_q      <= skip_d;
            key_q       <= key_d;
            err_q       <= err_d;
`ifdef TYPEMATIC_SUPPRESS_EN
            held_q      <= held_d;
`endif
        end
    end
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Scoreboard bench for ps2_scancode_receiver: directed PS/2 frames, expected events queued, monitor compares.
module tb_ps2_scancode_receiver;
    localparam int FL   = 8;
    localparam int TMO  = 2000;
    localparam int HALF = 30;

    typedef struct packed {
        logic        err;
        logic [10:0] key;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    ps2_scancode_receiver_if bus();

    ps2_scancode_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    logic [10:0] model_key = 11'h000;
    logic        prev_toggle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic exp_event(input logic ext, input logic pressed, input logic [7:0] code);
        exp_t e;
        model_key = {~model_key[10], pressed, ext, code};
        e.err = 1'b0;
        e.key = model_key;
        expq.push_back(e);
    endtask

    task automatic exp_err();
        exp_t e;
        e.err = 1'b1;
        e.key = model_key;
        expq.push_back(e);
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data_in = b;
        wait_clk(HALF);
        bus.ps2_clk_in = 1'b0;
        wait_clk(HALF);
        bus.ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        bus.ps2_data_in = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Monitor: every toggle of bit 10 or frame_err pulse consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.frame_err || (bus.ps2_key[10] != prev_toggle)) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got err=%0b key=%03h expected no event",
                             bus.frame_err, bus.ps2_key);
                end else begin
                    e = expq.pop_front();
                    if (bus.frame_err !== e.err || bus.ps2_key !== e.key) begin
                        errors++;
                        $display("FAIL event: got err=%0b key=%03h expected err=%0b key=%03h",
                                 bus.frame_err, bus.ps2_key, e.err, e.key);
                    end
                end
            end
        end
        prev_toggle = bus.ps2_key[10];
    end

    initial begin
        logic [7:0] seq [13];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hFA, 8'hAA, 8'hE0, 8'hFA, 8'h2A};
        bus.ps2_clk_in  = 1'b1;
        bus.ps2_data_in = 1'b1;
        wait_clk(5);
        reset = 1'b1;
        @(negedge clk);
        check("reset_key", 32'(bus.ps2_key), 32'h000);
        check("reset_err", 32'(bus.frame_err), 32'h0);

        exp_event(1'b0, 1'b1, 8'h1C);
        send_frame(8'h1C, 1'b0);
        exp_event(1'b0, 1'b0, 8'h1C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        exp_event(1'b1, 1'b1, 8'h75);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        exp_event(1'b1, 1'b0, 8'h75);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);

        exp_err();
        send_frame(8'h1C, 1'b1);
        exp_event(1'b0, 1'b1, 8'h24);
        send_frame(8'h24, 1'b0);

        exp_err();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        wait_clk(TMO - 100);
        check("timeout_not_early", 32'(expq.size()), 32'd1);
        wait_clk(300);
        exp_event(1'b0, 1'b1, 8'h1C);
        send_frame(8'h1C, 1'b0);

        bus.ps2_clk_in = 1'b0;
        wait_clk(FL - 1);
        bus.ps2_clk_in = 1'b1;
        wait_clk(50);
        for (int i = 0; i < 12; i++) send_frame(seq[i], 1'b0);
        exp_event(1'b0, 1'b1, 8'h2A);
        send_frame(seq[12], 1'b0);

        check("queue_before_reset", 32'(expq.size()), 32'd0);
        @(posedge clk);
        reset = 1'b0;
        wait_clk(3);
        reset = 1'b1;
        model_key = 11'h000;
        wait_clk(10);
        exp_event(1'b0, 1'b1, 8'h1C);
        send_frame(8'h1C, 1'b0);
`ifndef TYPEMATIC_SUPPRESS_EN
        exp_event(1'b0, 1'b1, 8'h1C);
`endif
        send_frame(8'h1C, 1'b0);
        exp_event(1'b0, 1'b0, 8'h1C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);

        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        @(posedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midframe_reset_key", 32'(bus.ps2_key), 32'h000);
        check("midframe_reset_err", 32'(bus.frame_err), 32'h0);
        wait_clk(2);
        reset = 1'b1;
        model_key = 11'h000;
        wait_clk(TMO + 200);

        for (int i = 0; i < 1000 && expq.size() != 0; i++) @(posedge clk);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
